// File: rtl/pll_ref_supervisor.sv
// pll_ref_supervisor
//   Control-plane companion for a PLL + reference-clock-select front end.
//   Holds the PLL in reset for a fixed time per attempt, waits for a qualified
//   lock, and requires a stable lock before raising READY. If lock is not
//   reached in time, or is lost while running, it fails over to the next
//   reference. After NUM_REFS*MAX_RETRIES consecutive failures it parks in FAULT
//   until RESTART.
//
//   Optional feature: define PLL_REF_REVERT_EN to build the revert-to-preferred
//   dwell counter. The default build (macro undefined) stays on the current
//   reference until it fails.
//
// Ports
//   i_clki        in   1      free-running control clock (never the PLL output)
//   i_rst         in   1      asynchronous active-high reset
//   i_lock_in     in   1      PLL LOCK, asynchronous to i_clki
//   i_pref_sel    in   SEL_W  preferred reference index, quasi-static
//   i_restart     in   1      single-cycle pulse; acted on only in S_FAULT
//   o_pll_rst     out  1      PLL reset
//   o_sel         out  SEL_W  reference-select mux control
//   o_ready       out  1      PLL output usable
//   o_fault       out  1      all references exhausted
//   o_switch_cnt  out  8      reference switches since reset, saturating
//   o_state       out  3      current FSM state (debug)
//
// Handshake: there is no valid/ready interface. i_restart is a one-cycle
// request pulse sampled on i_clki; it is ignored in every state but S_FAULT.

module pll_ref_supervisor #(
  parameter int NUM_REFS      = 2,
  parameter int SEL_W         = 1,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int LOSS_FILT     = 4,
  parameter int MAX_RETRIES   = 2,
  parameter int REVERT_CYCLES = 65536
) (
  input  logic             i_clki,
  input  logic             i_rst,
  input  logic             i_lock_in,
  input  logic [SEL_W-1:0] i_pref_sel,
  input  logic             i_restart,
  output logic             o_pll_rst,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_ready,
  output logic             o_fault,
  output logic [7:0]       o_switch_cnt,
  output logic [2:0]       o_state
);

  localparam int MAX_FAIL = NUM_REFS * MAX_RETRIES;
  localparam int RST_W    = $clog2(RST_CYCLES + 1);
  localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam int LOSS_W   = $clog2(LOSS_FILT + 1);
  localparam int FAIL_W   = $clog2(MAX_FAIL + 1);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILT - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [SEL_W:0]    NUM_REFS_X = (SEL_W + 1)'(NUM_REFS);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_REFS - 1);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_SWITCH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_lock_meta;
  logic                r_lock_s;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [LOSS_W-1:0]   r_loss_cnt;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [7:0]          r_switch_cnt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_sel_tgt;
  logic                r_pref_init;
  logic [SEL_W-1:0]    w_pref_clean;
  logic [SEL_W-1:0]    w_sel_adv;

`ifdef PLL_REF_REVERT_EN
  localparam int DWELL_W = $clog2(REVERT_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(REVERT_CYCLES - 1);
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic [SEL_W-1:0]    r_pref;
`endif

  // Out-of-range preferred indices fall back to reference 0.
  assign w_pref_clean = ({1'b0, i_pref_sel} < NUM_REFS_X) ? i_pref_sel : '0;
  assign w_sel_adv    = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;

  // Two-flop synchroniser; every decision below uses r_lock_s.
  always_ff @(posedge i_clki or posedge i_rst) begin
    if (i_rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_lock_in;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge i_clki or posedge i_rst) begin
    if (i_rst) r_state <= S_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:    if (r_rst_cnt == RST_LAST) w_next = S_WAIT;
      S_WAIT: begin
        if (r_lock_s)                 w_next = S_STABLE;
        else if (r_to_cnt == TO_LAST) w_next = S_SWITCH;
      end
      S_STABLE: begin
        if (!r_lock_s)                     w_next = S_WAIT;
        else if (r_stab_cnt == STAB_LAST)  w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_lock_s && (r_loss_cnt == LOSS_LAST)) w_next = S_SWITCH;
`ifdef PLL_REF_REVERT_EN
        else if ((r_sel != r_pref) && (r_dwell_cnt == DWELL_LAST)) w_next = S_RST;
`endif
      end
      // r_fail_cnt is compared before its increment in this same cycle.
      S_SWITCH: w_next = (r_fail_cnt == FAIL_LAST) ? S_FAULT : S_RST;
      S_FAULT:  if (i_restart) w_next = S_RST;
      default:  w_next = S_RST;
    endcase
  end

  always_ff @(posedge i_clki or posedge i_rst) begin
    if (i_rst) begin
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_stab_cnt   <= STAB_W'(1);
      r_loss_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_switch_cnt <= 8'd0;
    end else begin
      if ((r_state == S_RST) && (w_next == S_RST)) r_rst_cnt <= r_rst_cnt + 1'b1;
      else                                         r_rst_cnt <= '0;

      // The timeout spans every WAIT visit of one attempt, so a drop out of
      // S_STABLE resumes where it left off.
      if (r_state == S_RST)
        r_to_cnt <= '0;
      else if ((r_state == S_WAIT) && (w_next == S_WAIT))
        r_to_cnt <= r_to_cnt + 1'b1;

      // Entry from S_WAIT already saw one locked cycle, hence the reload to 1.
      if ((r_state == S_STABLE) && (w_next == S_STABLE)) r_stab_cnt <= r_stab_cnt + 1'b1;
      else                                               r_stab_cnt <= STAB_W'(1);

      if ((r_state == S_RUN) && !r_lock_s) r_loss_cnt <= r_loss_cnt + 1'b1;
      else                                 r_loss_cnt <= '0;

      if (r_state == S_SWITCH)
        r_fail_cnt <= r_fail_cnt + 1'b1;
      else if ((w_next == S_RUN) && (r_state != S_RUN))
        r_fail_cnt <= '0;
      else if ((r_state == S_FAULT) && i_restart)
        r_fail_cnt <= '0;

      if ((r_state == S_SWITCH) && (r_switch_cnt != 8'hFF))
        r_switch_cnt <= r_switch_cnt + 8'd1;
    end
  end

  // r_sel_tgt is the reference for the next attempt. It is copied to the mux
  // only on the first S_RST cycle so the select never moves while the PLL runs.
  always_ff @(posedge i_clki or posedge i_rst) begin
    if (i_rst) begin
      r_pref_init <= 1'b0;
      r_sel_tgt   <= '0;
      r_sel       <= '0;
    end else begin
      if (!r_pref_init) begin
        r_pref_init <= 1'b1;
        r_sel_tgt   <= w_pref_clean;
      end else if ((r_state == S_FAULT) && i_restart) begin
        r_sel_tgt   <= w_pref_clean;
      end else if (r_state == S_SWITCH) begin
        r_sel_tgt   <= w_sel_adv;
`ifdef PLL_REF_REVERT_EN
      end else if ((r_state == S_RUN) && (w_next == S_RST)) begin
        r_sel_tgt   <= r_pref;
`endif
      end

      if ((r_state == S_RST) && (r_rst_cnt == '0))
        r_sel <= r_pref_init ? r_sel_tgt : w_pref_clean;
    end
  end

`ifdef PLL_REF_REVERT_EN
  always_ff @(posedge i_clki or posedge i_rst) begin
    if (i_rst) begin
      r_pref      <= '0;
      r_dwell_cnt <= '0;
    end else begin
      if (!r_pref_init || ((r_state == S_FAULT) && i_restart))
        r_pref <= w_pref_clean;

      if ((r_state == S_RUN) && (r_sel != r_pref)) r_dwell_cnt <= r_dwell_cnt + 1'b1;
      else                                         r_dwell_cnt <= '0;
    end
  end
`endif

  // Outputs decode the registered state; the async reset forces S_RST, so
  // PLL reset is asserted the moment i_rst rises.
  assign o_pll_rst    = (r_state == S_RST) || (r_state == S_SWITCH) || (r_state == S_FAULT);
  assign o_ready      = (r_state == S_RUN);
  assign o_fault      = (r_state == S_FAULT);
  assign o_sel        = r_sel;
  assign o_switch_cnt = r_switch_cnt;
  assign o_state      = r_state;

endmodule
